case_5_acc_15s_20s: RTL and testbench
=====================================

Name: case_5_acc_15s_20s

Overview:
Downstream consumer of the 10s x 5s -> 15s signed product stage. It accumulates LEN consecutive 15-bit signed products into a saturating ACC_WIDTH-bit signed sum. Control uses ap_ctrl_hs-style start/done. Products arrive on a valid/ready stream; the result leaves on an ap_vld-style output.

Parameters:
IN_WIDTH, 15, width of the signed product input
ACC_WIDTH, 20, width of the signed accumulator and result
LEN, 8, number of products per accumulation (>= 1)
CNT_WIDTH, 4, term counter width; must satisfy 2^CNT_WIDTH > LEN

Ports:
ap_clk  in  1  clock; all state updates on rising edge
ap_rst  in  1  synchronous reset, active-high
ap_start  in  1  request a new accumulation
ap_done  out  1  one-cycle pulse when the result is presented
ap_idle  out  1  high while in S_IDLE
ap_ready  out  1  one-cycle pulse, coincident with ap_done
prod_din  in  IN_WIDTH  signed product from the multiplier stage
prod_vld  in  1  prod_din valid
prod_rdy  out  1  block accepts prod_din this cycle
acc_out  out  ACC_WIDTH  signed accumulated result
acc_out_ap_vld  out  1  acc_out valid; one-cycle pulse
ovf  out  1  saturation occurred in the last completed run

Behaviour:
- Reset (ap_rst=1 at an edge) forces the following, regardless of state:
  - state=S_IDLE, acc=0, cnt=0, acc_out=0, ovf=0, internal sticky flag=0.
  - ap_done=0, ap_ready=0, acc_out_ap_vld=0, prod_rdy=0, ap_idle=1 from the next cycle.
  - Reset mid-run abandons the run with no done pulse.
- FSM, three states, one-hot or binary:
  - S_IDLE: ap_idle=1, prod_rdy=0. If ap_start=1, then next acc=0, cnt=0, sticky=0, state=S_ACC.
  - S_ACC: ap_idle=0, prod_rdy=1 (combinational from state only).
    - On an accept (prod_vld & prod_rdy): acc <= sat(acc + sext(prod_din)) and cnt <= cnt+1.
    - If the accept happens with cnt==LEN-1, next state=S_DONE.
    - With no accept, all state holds (bubbles allowed, unbounded).
  - S_DONE, exactly one cycle:
    - ap_done=1, ap_ready=1, acc_out_ap_vld=1, prod_rdy=0.
    - acc_out shows the final acc; ovf shows sticky.
    - Next state=S_IDLE unconditionally. ap_start during S_DONE is ignored and is sampled again in S_IDLE.
- Output registers:
  - acc_out and ovf are loaded on the S_ACC -> S_DONE transition.
  - They hold until the next S_DONE or reset.
  - ap_done, ap_ready and acc_out_ap_vld are registered; latency from the last accept to the done pulse is 1 cycle.
- Arithmetic:
  - prod_din is sign-extended to ACC_WIDTH+1 bits and added to acc, also sign-extended.
  - If the sum > 2^(ACC_WIDTH-1)-1, clip to that maximum; if it < -2^(ACC_WIDTH-1), clip to that minimum.
  - A clip sets sticky=1. Accumulation continues from the clipped value.
- Boundary conditions:
  - At defaults, the worst case 8 x (-16384) = -131072 fits and never saturates.
  - LEN=1: the first accept goes directly to S_DONE.
  - prod_din while prod_rdy=0 is not consumed; the upstream must hold it.
- Throughput: LEN accepts, plus 1 S_DONE cycle, plus 1 S_IDLE cycle minimum between runs.

Test Plan:
1. Reset, then ap_start=1 for 1 cycle; feed prod_din 1..8 back-to-back -> ap_done one cycle after the 8th accept; acc_out=36, ovf=0, acc_out_ap_vld a one-cycle pulse.
2. Feed 8 x -16384 with prod_vld toggling 1/0 every cycle -> bubbles ignored; acc_out=-131072 (20'h E0000), ovf=0; completes 16 cycles after the first accept.
3. ACC_WIDTH=16: feed 8 x 16383 -> acc_out=32767, ovf=1. Next run feeds 8 x 1 -> acc_out=8, ovf=0 (sticky cleared on start).
4. Assert ap_rst after 4 accepts -> no ap_done; ap_idle=1 and acc_out=0 after reset. A fresh run of 8 x -3 -> acc_out=-24.
5. LEN=1: start, then feed -7 -> ap_done one cycle later; acc_out=-7. Hold ap_start high continuously -> runs repeat every 3 cycles and ap_start in S_DONE is not double-counted.
6. prod_vld=1 while in S_IDLE before start -> prod_rdy=0 and the value is not consumed; after start, the held value is accepted as the first term.

Source files
------------

// File: rtl/case_5_acc_15s_20s.sv
// Saturating accumulator of LEN signed products with ap_ctrl_hs start/done; result
// registered one cycle after the last accept; prod_rdy high only while accumulating.
module case_5_acc_15s_20s #(
   parameter int IN_WIDTH  = 15,
   parameter int ACC_WIDTH = 20,
   parameter int LEN       = 8,
   parameter int CNT_WIDTH = 4
) (
   input  logic                 ap_clk,
   input  logic                 ap_rst,
   input  logic                 ap_start,
   output logic                 ap_done,
   output logic                 ap_idle,
   output logic                 ap_ready,
   input  logic [IN_WIDTH-1:0]  prod_din,
   input  logic                 prod_vld,
   output logic                 prod_rdy,
   output logic [ACC_WIDTH-1:0] acc_out,
   output logic                 acc_out_ap_vld,
   output logic                 ovf
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [ACC_WIDTH-1:0] ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(LEN - 1);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [ACC_WIDTH-1:0]   r_acc;
   logic [CNT_WIDTH-1:0]   r_cnt;
   logic                   r_sticky;
   logic                   r_done;
   logic [ACC_WIDTH-1:0]   r_acc_out;
   logic                   r_ovf;

   logic                   w_accept;
   logic                   w_last;
   logic [ACC_WIDTH:0]     w_sum;
   logic                   w_clip;
   logic [ACC_WIDTH-1:0]   w_sat;

   assign w_accept = (r_state == S_ACC) && prod_vld;
   assign w_last   = w_accept && (r_cnt == CNT_LAST);

   // One guard bit: overflow shows up as disagreement between the top two sum bits.
   assign w_sum  = {r_acc[ACC_WIDTH-1], r_acc}
                 + {{(ACC_WIDTH+1-IN_WIDTH){prod_din[IN_WIDTH-1]}}, prod_din};
   assign w_clip = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
   assign w_sat  = w_clip ? (w_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : w_sum[ACC_WIDTH-1:0];

   always_ff @(posedge ap_clk) begin
      if (ap_rst) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (ap_start) w_state_nxt = S_ACC;
         S_ACC:   if (w_last)   w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_acc     <= '0;
         r_cnt     <= '0;
         r_sticky  <= 1'b0;
         r_done    <= 1'b0;
         r_acc_out <= '0;
         r_ovf     <= 1'b0;
      end else begin
         r_done <= w_last;
         if (r_state == S_IDLE && ap_start) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
         end else if (w_accept) begin
            r_acc <= w_sat;
            r_cnt <= r_cnt + 1'b1;
            if (w_clip) r_sticky <= 1'b1;
         end
         // Capture the final term directly so the result is ready in S_DONE.
         if (w_last) begin
            r_acc_out <= w_sat;
            r_ovf     <= r_sticky | w_clip;
         end
      end
   end

   assign ap_done        = r_done;
   assign ap_ready       = r_done;
   assign acc_out_ap_vld = r_done;
   assign ap_idle        = (r_state == S_IDLE);
   assign prod_rdy       = (r_state == S_ACC);
   assign acc_out        = r_acc_out;
   assign ovf            = r_ovf;

endmodule

// File: tb/tb_case_5_acc_15s_20s.sv
// Directed bench for case_5_acc_15s_20s: default, 16-bit accumulator and LEN=1 instances.
module tb_case_5_acc_15s_20s;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   logic        a_start, a_vld, a_done, a_idle, a_ready, a_rdy, a_avld, a_ovf;
   logic [14:0] a_din;
   logic [19:0] a_acc;
   logic        b_start, b_vld, b_done, b_idle, b_ready, b_rdy, b_avld, b_ovf;
   logic [14:0] b_din;
   logic [15:0] b_acc;
   logic        c_start, c_vld, c_done, c_idle, c_ready, c_rdy, c_avld, c_ovf;
   logic [14:0] c_din;
   logic [19:0] c_acc;

   case_5_acc_15s_20s u_a (
      .ap_clk(clk), .ap_rst(rst), .ap_start(a_start), .ap_done(a_done), .ap_idle(a_idle),
      .ap_ready(a_ready), .prod_din(a_din), .prod_vld(a_vld), .prod_rdy(a_rdy),
      .acc_out(a_acc), .acc_out_ap_vld(a_avld), .ovf(a_ovf));

   case_5_acc_15s_20s #(.ACC_WIDTH(16)) u_b (
      .ap_clk(clk), .ap_rst(rst), .ap_start(b_start), .ap_done(b_done), .ap_idle(b_idle),
      .ap_ready(b_ready), .prod_din(b_din), .prod_vld(b_vld), .prod_rdy(b_rdy),
      .acc_out(b_acc), .acc_out_ap_vld(b_avld), .ovf(b_ovf));

   case_5_acc_15s_20s #(.LEN(1)) u_c (
      .ap_clk(clk), .ap_rst(rst), .ap_start(c_start), .ap_done(c_done), .ap_idle(c_idle),
      .ap_ready(c_ready), .prod_din(c_din), .prod_vld(c_vld), .prod_rdy(c_rdy),
      .acc_out(c_acc), .acc_out_ap_vld(c_avld), .ovf(c_ovf));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc;
      int seen;
      int ndone;
      int bad;

      rst = 1'b1;
      a_start = 0; a_vld = 0; a_din = '0;
      b_start = 0; b_vld = 0; b_din = '0;
      c_start = 0; c_vld = 0; c_din = '0;
      tick; tick;
      rst = 1'b0;
      chk("rst_idle", a_idle, 1);
      chk("rst_done", a_done, 0);
      chk("rst_ready", a_ready, 0);
      chk("rst_avld", a_avld, 0);
      chk("rst_rdy", a_rdy, 0);
      chk("rst_acc", $signed(a_acc), 0);
      chk("rst_ovf", a_ovf, 0);

      // Back-to-back 1..8
      a_start = 1; tick; a_start = 0;
      chk("t1_rdy", a_rdy, 1);
      chk("t1_idle", a_idle, 0);
      for (int i = 1; i <= 8; i++) begin
         a_din = 15'(i); a_vld = 1;
         tick;
         if (i < 8) chk("t1_early_done", a_done, 0);
      end
      a_vld = 0;
      chk("t1_done", a_done, 1);
      chk("t1_ready", a_ready, 1);
      chk("t1_avld", a_avld, 1);
      chk("t1_rdy_in_done", a_rdy, 0);
      chk("t1_acc", $signed(a_acc), 36);
      chk("t1_ovf", a_ovf, 0);
      tick;
      chk("t1_done_pulse", a_done, 0);
      chk("t1_avld_pulse", a_avld, 0);
      chk("t1_back_idle", a_idle, 1);
      chk("t1_acc_hold", $signed(a_acc), 36);

      // Worst-case negative products with a bubble every other cycle
      a_start = 1; tick; a_start = 0;
      a_din = 15'h4000;
      cyc = 0; seen = 0;
      for (int k = 0; k < 40 && seen == 0; k++) begin
         a_vld = (k % 2 == 0);
         tick;
         cyc++;
         if (a_done) seen = 1;
      end
      a_vld = 0;
      chk("t2_done_seen", seen, 1);
      // cycles counted from the first accept through the done cycle
      chk("t2_cycles", cyc + 1, 16);
      chk("t2_acc", $signed(a_acc), -131072);
      chk("t2_acc_hex", int'(a_acc), 32'h000E0000);
      chk("t2_ovf", a_ovf, 0);
      tick;

      // 16-bit accumulator saturates, then sticky clears on the next start
      b_start = 1; tick; b_start = 0;
      b_din = 15'd16383; b_vld = 1;
      repeat (8) tick;
      b_vld = 0;
      chk("t3_done", b_done, 1);
      chk("t3_acc_sat", $signed(b_acc), 32767);
      chk("t3_ovf", b_ovf, 1);
      tick;
      chk("t3_ovf_hold", b_ovf, 1);
      b_start = 1; tick; b_start = 0;
      b_din = 15'd1; b_vld = 1;
      repeat (8) tick;
      b_vld = 0;
      chk("t3b_done", b_done, 1);
      chk("t3b_acc", $signed(b_acc), 8);
      chk("t3b_ovf", b_ovf, 0);
      tick;

      // Reset mid-run
      a_start = 1; tick; a_start = 0;
      a_din = 15'd5; a_vld = 1;
      repeat (4) tick;
      chk("t4_no_done_pre", a_done, 0);
      rst = 1; a_vld = 0;
      tick;
      rst = 0;
      chk("t4_idle", a_idle, 1);
      chk("t4_acc", $signed(a_acc), 0);
      chk("t4_ovf", a_ovf, 0);
      chk("t4_done", a_done, 0);
      chk("t4_rdy", a_rdy, 0);
      tick;
      chk("t4_no_done_post", a_done, 0);
      a_start = 1; tick; a_start = 0;
      a_din = -15'sd3; a_vld = 1;
      repeat (8) tick;
      a_vld = 0;
      chk("t4b_done", a_done, 1);
      chk("t4b_acc", $signed(a_acc), -24);
      tick;

      // LEN=1, then ap_start held high
      c_start = 1; tick; c_start = 0;
      c_din = -15'sd7; c_vld = 1;
      tick;
      chk("t5_done", c_done, 1);
      chk("t5_ready", c_ready, 1);
      chk("t5_acc", $signed(c_acc), -7);
      c_start = 1;
      ndone = 0; bad = 0;
      for (int k = 1; k <= 12; k++) begin
         tick;
         if (c_done) begin
            ndone++;
            if ($signed(c_acc) != -7 || (k % 3) != 0) bad++;
         end
      end
      chk("t5_repeat_count", ndone, 4);
      chk("t5_repeat_bad", bad, 0);
      c_start = 0; c_vld = 0;
      tick; tick;

      // Valid held in idle is not consumed until after start
      a_din = 15'd11; a_vld = 1;
      tick; tick;
      chk("t6_rdy_idle", a_rdy, 0);
      chk("t6_idle", a_idle, 1);
      chk("t6_no_done", a_done, 0);
      a_start = 1; tick; a_start = 0;
      chk("t6_rdy_acc", a_rdy, 1);
      tick;
      a_din = 15'd1;
      repeat (7) tick;
      a_vld = 0;
      chk("t6_done", a_done, 1);
      chk("t6_acc", $signed(a_acc), 18);
      tick;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
